uart_rx_gen: RTL
================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal 1..2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two, 2..16.
REQ-004 SHALL have port Clock  input  1  single system clock, rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port DataTx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port ParityType  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port BaudDiv  input  16  Clock cycles per oversample tick; 0 treated as 1.
REQ-009 SHALL have port ReadEn  input  1  pop FIFO head.
REQ-010 SHALL have port ClearOverrun  input  1  clears Overrun.
REQ-011 SHALL have port Data  output  DATA_BITS  FIFO head data, LSB first received.
REQ-012 SHALL have port DataValid  output  1  FIFO not empty.
REQ-013 SHALL have port ParityError  output  1  parity error flag of FIFO head word.
REQ-014 SHALL have port FrameError  output  1  stop-bit error flag of FIFO head word.
REQ-015 SHALL have port Overrun  output  1  sticky: a completed frame was dropped.
REQ-016 SHALL have port Busy  output  1  FSM not in IDLE.
REQ-017 SHALL have port FifoCount  output  clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-018 DataTx SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-019 Prescaler SHALL emit a one-cycle tick every max(BaudDiv,1) Clock cycles; 16 ticks = one bit period.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 IDLE: synchronized line low -> START, prescaler and tick counter cleared; ParityType and BaudDiv latched for the whole frame.
REQ-022 Each bit value SHALL be the majority of samples at ticks 7, 8, 9 of its bit period.
REQ-023 START: majority high -> IDLE (false start, nothing written); else -> DATA at end of bit period.
REQ-024 DATA: DATA_BITS bits shifted LSB first; then PARITY if latched type is 01/10, else STOP.
REQ-025 PARITY: odd type error when data+parity has even ones count; even type error when odd count.
REQ-026 STOP: STOP_BITS bits; any low stop sample sets frame error.
REQ-027 Word {data, parity err, frame err} SHALL be written to FIFO on the tick-9 edge of the final stop bit; no wait for end of stop period.
REQ-028 After write: line high -> IDLE; line low (frame error/break) -> WAIT_IDLE, which returns to IDLE only when line is high.
REQ-029 FIFO SHALL be first-word-fall-through; Data/ParityError/FrameError show head combinationally from storage, DataValid high the cycle after the first write.
REQ-030 ReadEn with FIFO empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-031 Write when full without same-cycle ReadEn SHALL drop the word and set Overrun; write and ReadEn same cycle when full SHALL both succeed, no overrun.
REQ-032 Overrun SHALL stay set until ClearOverrun; set and ClearOverrun same cycle -> Overrun stays 1.
REQ-033 Changes to ParityType/BaudDiv mid-frame SHALL NOT affect the current frame.

Reset
REQ-034 Reset SHALL asynchronously force FSM to IDLE, counters and FIFO pointers to 0, synchronizer to 1.
REQ-035 During reset: Data=0, DataValid=0, ParityError=0, FrameError=0, Overrun=0, Busy=0, FifoCount=0.
REQ-036 Reset mid-frame SHALL discard the partial frame; no FIFO write.

Verification
REQ-037 BaudDiv=1, ParityType=10, send 0xA5 + parity 0 + stop -> Data=0xA5, ParityError=0, FrameError=0, FifoCount=1.
REQ-038 ParityType=01, send 0x3C with parity 0 -> Data=0x3C, ParityError=1.
REQ-039 Send 0x55 with stop bit low, line held low 40 bit periods -> FrameError=1, Busy high until line returns high, one word only.
REQ-040 Low glitch of 5 ticks on idle line -> back to IDLE, DataValid=0, FifoCount=0.
REQ-041 FIFO_DEPTH=4, send 5 frames with ReadEn=0 -> FifoCount=4, Overrun=1, head=first frame; ClearOverrun -> Overrun=0.
REQ-042 Assert Reset at data bit 3, release, send 0x81 -> only 0x81 in FIFO, FifoCount=1.

Source files
------------

// File: rtl/uart_rx_gen.sv
// UART receiver with 16x oversampling, 3-sample majority voting, optional parity,
// configurable stop bits and a first-word-fall-through receive FIFO.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | validating start bit (false start returns to IDLE)
// DATA      | shifting in DATA_BITS bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bits; word written at tick 9 of the last one
// WAIT_IDLE | line still low after a frame (break), waiting for high
module uart_rx_gen #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          DataTx,
   input  logic [1:0]                    ParityType,
   input  logic [15:0]                   BaudDiv,
   input  logic                          ReadEn,
   input  logic                          ClearOverrun,
   output logic [DATA_BITS-1:0]          Data,
   output logic                          DataValid,
   output logic                          ParityError,
   output logic                          FrameError,
   output logic                          Overrun,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   state_t               state, state_nxt;
   logic [1:0]           sync_q;
   logic                 line;
   logic [15:0]          pre_cnt;
   logic [15:0]          div_lat;
   logic [15:0]          eff_div;
   logic [1:0]           par_type_lat;
   logic [3:0]           tick_cnt;
   logic [3:0]           bit_cnt;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;
   logic                 fe_acc;
   logic                 active;
   logic                 tick;
   logic                 bit_mid;
   logic                 bit_end;
   logic                 maj;
   logic                 par_on;
   logic                 par_err;
   logic                 wr_en;
   logic                 wr_pe;
   logic                 wr_fe;

   logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
   logic                 mem_pe   [FIFO_DEPTH];
   logic                 mem_fe   [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 full;
   logic                 rd_do;
   logic                 wr_do;
   logic                 ovr_set;
   logic                 ovr;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], DataTx};
      end
   end

   assign line    = sync_q[1];
   assign eff_div = (BaudDiv == 16'd0) ? 16'd1 : BaudDiv;
   assign active  = (state != IDLE) && (state != WAIT_IDLE);
   assign tick    = active && (pre_cnt == 16'd0);
   assign bit_mid = tick && (tick_cnt == 4'd9);
   assign bit_end = tick && (tick_cnt == 4'd15);
   // samp[0]/samp[1] hold ticks 7/8; the live line is the tick-9 sample
   assign maj     = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);
   assign par_on  = par_type_lat[0] ^ par_type_lat[1];
   assign par_err = par_on && ((par_type_lat == 2'b01) ? ~par_acc : par_acc);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_pe     = 1'b0;
      wr_fe     = 1'b0;
      case (state)
         IDLE: begin
            if (!line) state_nxt = START;
         end
         START: begin
            if (bit_mid && maj)  state_nxt = IDLE;
            else if (bit_end)    state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && (bit_cnt == 4'd0)) state_nxt = par_on ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_mid && (bit_cnt == 4'd0)) begin
               wr_en     = 1'b1;
               wr_pe     = par_err;
               wr_fe     = fe_acc | ~maj;
               state_nxt = line ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (line) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pre_cnt      <= 16'd0;
         div_lat      <= 16'd1;
         par_type_lat <= 2'b00;
         tick_cnt     <= 4'd0;
         bit_cnt      <= 4'd0;
         samp         <= 2'b11;
         shreg        <= '0;
         par_acc      <= 1'b0;
         fe_acc       <= 1'b0;
      end else if (state == IDLE) begin
         if (!line) begin
            div_lat      <= eff_div;
            par_type_lat <= ParityType;
            pre_cnt      <= eff_div - 16'd1;
            tick_cnt     <= 4'd0;
            par_acc      <= 1'b0;
            fe_acc       <= 1'b0;
         end
      end else if (tick) begin
         pre_cnt  <= div_lat - 16'd1;
         tick_cnt <= tick_cnt + 4'd1;
         if (tick_cnt == 4'd7) samp[0] <= line;
         if (tick_cnt == 4'd8) samp[1] <= line;
         if (bit_mid) begin
            case (state)
               DATA: begin
                  shreg   <= {maj, shreg[DATA_BITS-1:1]};
                  par_acc <= par_acc ^ maj;
               end
               PARITY:  par_acc <= par_acc ^ maj;
               STOP:    if (!maj) fe_acc <= 1'b1;
               default: ;
            endcase
         end
         if (bit_end) begin
            case (state)
               START:   bit_cnt <= DATA_LAST;
               DATA:    bit_cnt <= (bit_cnt == 4'd0) ? STOP_LAST : bit_cnt - 4'd1;
               PARITY:  bit_cnt <= STOP_LAST;
               STOP:    bit_cnt <= bit_cnt - 4'd1;
               default: ;
            endcase
         end
      end else if (active) begin
         pre_cnt <= pre_cnt - 16'd1;
      end
   end

   assign full    = (count == FULL_CNT);
   assign rd_do   = ReadEn && (count != '0);
   assign wr_do   = wr_en && (!full || rd_do);
   assign ovr_set = wr_en && full && !rd_do;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_pe[i]   <= 1'b0;
            mem_fe[i]   <= 1'b0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr    <= 1'b0;
      end else begin
         if (wr_do) begin
            mem_data[wr_ptr] <= shreg;
            mem_pe[wr_ptr]   <= wr_pe;
            mem_fe[wr_ptr]   <= wr_fe;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (rd_do) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_do, rd_do})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         // a same-cycle set wins over the clear
         if (ClearOverrun) ovr <= 1'b0;
         if (ovr_set)      ovr <= 1'b1;
      end
   end

   assign Data        = mem_data[rd_ptr];
   assign ParityError = mem_pe[rd_ptr];
   assign FrameError  = mem_fe[rd_ptr];
   assign DataValid   = (count != '0);
   assign Overrun     = ovr;
   assign Busy        = (state != IDLE);
   assign FifoCount   = count;

endmodule
